// File: rtl/calc_pkg.sv
// Shared calculator definitions: key codes, keypad entry state encoding and digit count.
package calc_pkg;

   localparam int unsigned N_DIG = 4;
   localparam int unsigned DIG_W = 4;

   localparam logic [3:0] KEY_MAX_DIGIT = 4'h9;
   localparam logic [3:0] KEY_CLR       = 4'hA;
   localparam logic [3:0] KEY_BKSP      = 4'hB;
   localparam logic [3:0] KEY_ENT       = 4'hC;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ENTRY = 2'd1,
      ST_FULL  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   function automatic logic is_digit(input logic [3:0] code);
      return code <= KEY_MAX_DIGIT;
   endfunction

endpackage

// File: rtl/entrada_bcd_if.sv
// Keypad-side and consumer-side signals of the BCD entry block.
interface entrada_bcd_if #(
   parameter int unsigned N_DIG = calc_pkg::N_DIG
) ();
   localparam int unsigned DW = 4 * N_DIG;
   localparam int unsigned CW = $clog2(N_DIG + 1);

   logic          key_valid;
   logic [3:0]    key_code;
   logic          num_ack;
   logic [DW-1:0] num_BCD;
   logic [CW-1:0] n_digits;
   logic          num_valid;
   logic          key_err;

   modport master (
      output key_valid, key_code, num_ack,
      input  num_BCD, n_digits, num_valid, key_err
   );

   modport slave (
      input  key_valid, key_code, num_ack,
      output num_BCD, n_digits, num_valid, key_err
   );
endinterface

// File: rtl/entrada_bcd.sv
// Keypad BCD entry: shifts digits in, supports clear/backspace, and holds the
// committed number until the downstream BCD-to-binary stage acknowledges it.
module entrada_bcd
   import calc_pkg::*;
#(
   parameter int unsigned N_DIG = calc_pkg::N_DIG
) (
   input logic         clk,
   input logic         rst,
   entrada_bcd_if.slave bus
);

   localparam int unsigned DW = DIG_W * N_DIG;
   localparam int unsigned CW = $clog2(N_DIG + 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(N_DIG);

   state_t        state;
   logic [DW-1:0] num_q;
   logic [CW-1:0] cnt_q;
   logic          valid_q;
   logic          err_q;

   logic [CW-1:0] cnt_inc;
   logic [CW-1:0] cnt_dec;
   logic [DW-1:0] num_shl;
   logic [DW-1:0] num_shr;

   assign cnt_inc = cnt_q + CW'(1);
   assign cnt_dec = cnt_q - CW'(1);
   assign num_shl = {num_q[DW-DIG_W-1:0], bus.key_code};
   assign num_shr = {DIG_W'(0), num_q[DW-1:DIG_W]};

   function automatic state_t count_state(input logic [CW-1:0] cnt);
      if (cnt == '0)       return ST_EMPTY;
      if (cnt == CNT_FULL) return ST_FULL;
      return ST_ENTRY;
   endfunction

   // Entry FSM; every output is a flop, key_err self-clears each cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_EMPTY;
         num_q   <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state)
            ST_DONE: begin
               // Acknowledge wins over a coincident key, which is discarded silently
               if (bus.num_ack) begin
                  state   <= ST_EMPTY;
                  num_q   <= '0;
                  cnt_q   <= '0;
                  valid_q <= 1'b0;
               end else if (bus.key_valid) begin
                  err_q <= 1'b1;
               end
            end
            default: begin
               if (bus.key_valid) begin
                  if (is_digit(bus.key_code)) begin
                     if (state == ST_FULL) begin
                        err_q <= 1'b1;
                     end else if (!(state == ST_EMPTY && bus.key_code == 4'h0)) begin
                        num_q <= num_shl;
                        cnt_q <= cnt_inc;
                        state <= count_state(cnt_inc);
                     end
                  end else begin
                     case (bus.key_code)
                        KEY_CLR: begin
                           num_q <= '0;
                           cnt_q <= '0;
                           state <= ST_EMPTY;
                        end
                        KEY_BKSP: begin
                           if (state == ST_EMPTY) begin
                              err_q <= 1'b1;
                           end else begin
                              num_q <= num_shr;
                              cnt_q <= cnt_dec;
                              state <= count_state(cnt_dec);
                           end
                        end
                        KEY_ENT: begin
                           state   <= ST_DONE;
                           valid_q <= 1'b1;
                        end
                        default: err_q <= 1'b1;
                     endcase
                  end
               end
            end
         endcase
      end
   end

   assign bus.num_BCD   = num_q;
   assign bus.n_digits  = cnt_q;
   assign bus.num_valid = valid_q;
   assign bus.key_err   = err_q;

endmodule

// File: tb/tb_entrada_bcd.sv
// Directed bench for entrada_bcd; committed numbers are checked by a scoreboard monitor.
module tb_entrada_bcd;
   import calc_pkg::*;

   typedef struct {
      logic [15:0] bcd;
      logic [2:0]  nd;
   } commit_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   passed = 0;
   int   total = 0;
   int   err_seen = 0;
   logic prev_valid = 1'b0;
   commit_t sb[$];

   entrada_bcd_if #(.N_DIG(4)) bus ();

   entrada_bcd #(.N_DIG(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic chk_out(input string name, input logic [15:0] bcd, input logic [2:0] nd,
                          input logic v);
      chk({name, ".num_BCD"}, 32'(bus.num_BCD), 32'(bcd));
      chk({name, ".n_digits"}, 32'(bus.n_digits), 32'(nd));
      chk({name, ".num_valid"}, 32'(bus.num_valid), 32'(v));
   endtask

   task automatic chk_err(input string name, input int base, input int delta);
      chk({name, ".key_err_count"}, 32'(err_seen - base), 32'(delta));
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic press(input logic [3:0] code);
      bus.key_valid = 1'b1;
      bus.key_code  = code;
      tick();
      bus.key_valid = 1'b0;
      bus.key_code  = 4'h0;
   endtask

   task automatic commit(input logic [15:0] bcd, input logic [2:0] nd);
      commit_t c;
      c.bcd = bcd;
      c.nd  = nd;
      sb.push_back(c);
      press(KEY_ENT);
   endtask

   task automatic ack();
      bus.num_ack = 1'b1;
      tick();
      bus.num_ack = 1'b0;
   endtask

   // Monitor: count key_err pulses and check each newly committed number
   always @(negedge clk) begin
      commit_t c;
      if (bus.key_err) err_seen++;
      if (bus.num_valid && !prev_valid) begin
         total++;
         if (sb.size() == 0) begin
            $display("FAIL commit_unexpected: got %0h with empty queue", bus.num_BCD);
         end else begin
            c = sb.pop_front();
            if (bus.num_BCD === c.bcd && bus.n_digits === c.nd) passed++;
            else $display("FAIL commit: got %0h/%0d expected %0h/%0d",
                          bus.num_BCD, bus.n_digits, c.bcd, c.nd);
         end
      end
      prev_valid = bus.num_valid;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int base;
      bus.key_valid = 1'b0;
      bus.key_code  = 4'h0;
      bus.num_ack   = 1'b0;
      #2;
      chk_out("reset", 16'h0000, 3'd0, 1'b0);
      chk("reset.key_err", 32'(bus.key_err), 32'd0);
      tick();
      tick();
      rst = 1'b0;

      // Digit entry up to FULL, then an overflow digit
      base = err_seen;
      press(4'h1); press(4'h2); press(4'h3);
      chk_out("entry3", 16'h0123, 3'd3, 1'b0);
      press(4'h4);
      chk_out("full", 16'h1234, 3'd4, 1'b0);
      press(4'h5);
      chk_out("overflow", 16'h1234, 3'd4, 1'b0);
      chk_err("overflow", base, 1);
      commit(16'h1234, 3'd4);
      chk_out("commit1234", 16'h1234, 3'd4, 1'b1);
      ack();
      chk_out("ack1234", 16'h0000, 3'd0, 1'b0);

      // Leading zeros and backspace
      base = err_seen;
      press(4'h0); press(4'h0);
      chk_out("leadzero", 16'h0000, 3'd0, 1'b0);
      press(4'h7);
      chk_out("seven", 16'h0007, 3'd1, 1'b0);
      press(KEY_BKSP);
      chk_out("bksp_to_empty", 16'h0000, 3'd0, 1'b0);
      press(4'h9);
      chk_out("nine", 16'h0009, 3'd1, 1'b0);
      chk_err("leadzero_bksp", base, 0);
      commit(16'h0009, 3'd1);
      ack();

      // Handshake: hold without ack, keys during DONE are dropped
      press(4'h5); press(4'h6);
      commit(16'h0056, 3'd2);
      base = err_seen;
      for (int i = 0; i < 10; i++) begin
         if (i == 4) press(4'h5);
         else if (i == 7) press(KEY_CLR);
         else tick();
         chk_out($sformatf("hold%0d", i), 16'h0056, 3'd2, 1'b1);
      end
      chk_err("done_drop", base, 2);
      ack();
      chk_out("ack0056", 16'h0000, 3'd0, 1'b0);
      press(4'h1);
      chk_out("after_ack_empty", 16'h0001, 3'd1, 1'b0);
      press(KEY_CLR);
      chk_out("clr", 16'h0000, 3'd0, 1'b0);

      // Ack and key in the same DONE cycle
      press(4'h3);
      commit(16'h0003, 3'd1);
      base = err_seen;
      bus.num_ack   = 1'b1;
      bus.key_valid = 1'b1;
      bus.key_code  = 4'h3;
      tick();
      bus.num_ack   = 1'b0;
      bus.key_valid = 1'b0;
      chk_out("simul", 16'h0000, 3'd0, 1'b0);
      chk("simul.key_err", 32'(bus.key_err), 32'd0);
      chk_err("simul", base, 0);

      // Asynchronous reset mid-entry
      press(4'h4); press(4'h2);
      chk_out("pre_rst", 16'h0042, 3'd2, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk_out("async_rst", 16'h0000, 3'd0, 1'b0);
      tick();
      rst = 1'b0;
      press(4'h8);
      chk_out("post_rst", 16'h0008, 3'd1, 1'b0);
      commit(16'h0008, 3'd1);
      ack();

      // Invalid code, BKSP in EMPTY, backspace from FULL, ENT in EMPTY
      base = err_seen;
      press(4'h1);
      press(4'hE);
      chk_out("invalid", 16'h0001, 3'd1, 1'b0);
      chk_err("invalid", base, 1);
      press(KEY_CLR);
      press(KEY_BKSP);
      chk_out("bksp_empty", 16'h0000, 3'd0, 1'b0);
      chk_err("bksp_empty", base, 2);
      press(4'h1); press(4'h2); press(4'h3); press(4'h4);
      press(KEY_BKSP);
      chk_out("bksp_full", 16'h0123, 3'd3, 1'b0);
      press(KEY_CLR);
      commit(16'h0000, 3'd0);
      chk_out("ent_empty", 16'h0000, 3'd0, 1'b1);
      ack();
      chk_out("final", 16'h0000, 3'd0, 1'b0);

      tick();
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/entrada_bcd.md
ENTRADA_BCD -- requirements
Module: entrada_bcd

Interface
REQ-001 SHALL have parameter N_DIG, default 4, meaning the number of BCD digits held (output width 4*N_DIG).
REQ-002 SHALL have port clk, input, 1, the single system clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst, input, 1, an asynchronous active-high reset.
REQ-004 SHALL have port key_valid, input, 1, a one-cycle strobe marking key_code as valid.
REQ-005 SHALL have port key_code, input, 4, with 0x0-0x9 as digits, 0xA as clear (CLR), 0xB as backspace (BKSP), 0xC as enter (ENT), and 0xD-0xF as invalid.
REQ-006 SHALL have port num_ack, input, 1, with which the consumer acknowledges num_BCD.
REQ-007 SHALL have port num_BCD, output, 16, the packed BCD value with digit 0 in bits [3:0], fed to the BCD-to-binary stage.
REQ-008 SHALL have port n_digits, output, 3, the count of significant digits entered (0..4).
REQ-009 SHALL have port num_valid, output, 1, high while num_BCD holds a committed number.
REQ-010 SHALL have port key_err, output, 1, a one-cycle pulse when a key is rejected.

Function
REQ-011 SHALL implement the states EMPTY (n_digits=0), ENTRY (1..3 digits), FULL (4 digits) and DONE (committed, awaiting ack).
REQ-012 SHALL, on a digit in EMPTY or ENTRY, set num_BCD <= {num_BCD[11:0], digit} and n_digits <= n_digits+1, moving to ENTRY, or to FULL when the count reaches 4.
REQ-013 SHALL treat digit 0 in EMPTY as a leading zero: num_BCD and n_digits remain 0, the state remains EMPTY, and no key_err pulse occurs.
REQ-014 SHALL, on a digit in FULL, leave num_BCD unchanged and pulse key_err for one cycle.
REQ-015 SHALL, on BKSP in ENTRY or FULL, set num_BCD <= {4'h0, num_BCD[15:4]} and n_digits <= n_digits-1, moving to EMPTY, ENTRY or FULL according to the new count.
REQ-016 SHALL ignore BKSP in EMPTY and pulse key_err.
REQ-017 SHALL, on CLR in EMPTY, ENTRY or FULL, set num_BCD=0 and n_digits=0, moving to EMPTY.
REQ-018 SHALL, on ENT in EMPTY, ENTRY or FULL, move to DONE and assert num_valid on the next cycle; ENT in EMPTY commits the value 0.
REQ-019 SHALL, for an invalid code (0xD-0xF), change no state and pulse key_err.
REQ-020 SHALL, in DONE, hold num_BCD, n_digits and num_valid stable until num_ack is sampled high.
REQ-021 SHALL, in DONE with num_ack high, clear num_BCD, n_digits and num_valid on that edge and move to EMPTY.
REQ-022 SHALL, in DONE, drop any key_valid that is not accompanied by num_ack and pulse key_err; CLR is dropped as well.
REQ-023 SHALL, when num_ack and key_valid are high in the same DONE cycle, give num_ack priority, discard the key and raise no key_err.
REQ-024 SHALL ignore num_ack outside DONE.
REQ-025 SHALL ignore key_code whenever key_valid is low.
REQ-026 SHALL process one key per cycle, so back-to-back strobes are all processed with 1-cycle latency from strobe to updated outputs.
REQ-027 SHALL drive all outputs directly from registers, with no combinational path from input to output.
REQ-028 SHALL guarantee that every nibble of num_BCD is always in the range 0..9.

Reset
REQ-029 SHALL, while rst is high, force state=EMPTY, num_BCD=16'h0000, n_digits=0, num_valid=0 and key_err=0 immediately, regardless of clk.
REQ-030 SHALL, when rst asserts mid-entry or in DONE, discard the partial or committed number without completing the handshake.
REQ-031 SHALL accept a key on the first clk edge after rst deasserts.

Structure
REQ-032 SHALL place the key code constants (KEY_CLR, KEY_BKSP, KEY_ENT), the state encoding and N_DIG in the shared calculator package calc_pkg.
REQ-033 SHALL be a single module with no sub-module; the downstream BCD-to-binary stage stays a separate block.

Verification
REQ-034 SHALL verify digit entry: keys 1,2,3,4 then ENT produce num_BCD=16'h1234, n_digits=4 and num_valid=1; a 5th digit before ENT leaves 16'h1234 and gives one key_err pulse.
REQ-035 SHALL verify leading zeros and backspace: keys 0,0,7,BKSP,9 produce num_BCD=16'h0009, n_digits=1 and no key_err.
REQ-036 SHALL verify the handshake: with num_ack held low for 10 cycles after ENT, num_BCD stays stable; a key 5 during that window is dropped with key_err; when num_ack pulses, the next cycle shows num_valid=0, num_BCD=0 and state EMPTY.
REQ-037 SHALL verify simultaneous events: num_ack and key_valid with digit 3 in the same DONE cycle give state EMPTY with num_BCD=0 (the key is lost) and key_err=0.
REQ-038 SHALL verify reset mid-operation: after keys 4,2, asserting rst between clk edges clears outputs at once; after release, keys 8 then ENT give num_BCD=16'h0008.
REQ-039 SHALL verify invalid codes and empty-state edge cases: key 0xE pulses key_err with no state change; ENT in EMPTY gives num_valid=1 with num_BCD=0 and n_digits=0.
